// File: rtl/tpu_ctrl_pkg.sv
// Shared types for the PE array sequencer: FSM state enum, registered output flags
// and the skew/drain latency helper.
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic w_ready;
        logic x_ready;
    } seq_flags_t;

    // Input handshake to matching result row: skew through the rows plus drain across the columns.
    function automatic int unsigned seq_latency(input int unsigned rows, input int unsigned cols);
        return rows + cols - 1;
    endfunction

    function automatic seq_flags_t seq_flags(input seq_state_e s);
        seq_flags_t f;
        f.busy    = (s != IDLE);
        f.done    = (s == DONE);
        f.w_ready = (s == LOAD);
        f.x_ready = (s == STREAM);
        return f;
    endfunction

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Host/DMA-facing control bus of the PE array sequencer.
// master = front end driving jobs and streams, slave = the sequencer.
interface pe_array_sequencer_if #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             busy;
    logic             done;
    logic             w_valid;
    logic             w_ready;
    logic [ROWS-1:0]  store_weight;
    logic             x_valid;
    logic             x_ready;
    logic             lane_valid;
    logic             res_valid;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output start, num_vectors, w_valid, x_valid,
        input  busy, done, w_ready, store_weight, x_ready, lane_valid, res_valid, stall_cycles
    );

    modport slave (
        input  start, num_vectors, w_valid, x_valid,
        output busy, done, w_ready, store_weight, x_ready, lane_valid, res_valid, stall_cycles
    );
endinterface

// File: rtl/pe_valid_pipe.sv
// Single-bit DEPTH-stage shift register with async active-low reset;
// delays lane_valid to line up with results leaving the array.
module pe_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pe_array_sequencer.sv
// Weight-stationary PE array job sequencer: weight load, vector stream, drain, done.
// Optional stall counter built when SEQ_PERF_COUNTERS_EN is defined.
module pe_array_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pe_array_sequencer_if.slave bus
);

    localparam int unsigned LAT    = seq_latency(ROWS, COLS);
    localparam int unsigned RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DR_W   = $clog2(LAT + 1);

    localparam logic [RIDX_W-1:0] LAST_ROW   = RIDX_W'(ROWS - 1);
    localparam logic [DR_W-1:0]   DRAIN_LAST = DR_W'(LAT - 1);

    seq_state_e        state_q,   state_d;
    seq_flags_t        flags_q;
    logic [RIDX_W-1:0] row_idx_q, row_idx_d;
    logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]  num_vec_q, num_vec_d;
    logic [DR_W-1:0]   drain_q,   drain_d;
    logic [ROWS-1:0]   store_weight;
    logic              lane_valid;
    logic              res_valid;

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        vec_cnt_d = vec_cnt_q;
        num_vec_d = num_vec_q;
        drain_d   = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_vec_d = bus.num_vectors;
                    row_idx_d = '0;
                    vec_cnt_d = '0;
                    drain_d   = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (bus.w_valid) begin
                    row_idx_d = row_idx_q + RIDX_W'(1);
                    if (row_idx_q == LAST_ROW) begin
                        state_d = (num_vec_q == '0) ? DONE : STREAM;
                    end
                end
            end
            STREAM: begin
                if (bus.x_valid) begin
                    vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    if (vec_cnt_q == num_vec_q - CNT_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + DR_W'(1);
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they change exactly with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            flags_q   <= '0;
            row_idx_q <= '0;
            vec_cnt_q <= '0;
            num_vec_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            flags_q   <= seq_flags(state_d);
            row_idx_q <= row_idx_d;
            vec_cnt_q <= vec_cnt_d;
            num_vec_q <= num_vec_d;
            drain_q   <= drain_d;
        end
    end

    // Strobe is combinational so it coincides with the weight handshake.
    always_comb begin
        store_weight = '0;
        if (state_q == LOAD && bus.w_valid) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (row_idx_q == RIDX_W'(r)) begin
                    store_weight[r] = 1'b1;
                end
            end
        end
    end

    assign lane_valid = (state_q == STREAM) && bus.x_valid;

    pe_valid_pipe #(
        .DEPTH(LAT)
    ) u_res_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (lane_valid),
        .q_o  (res_valid)
    );

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && bus.start) begin
            stall_d = '0;
        end else if (state_q == STREAM && !bus.x_valid && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.busy         = flags_q.busy;
    assign bus.done         = flags_q.done;
    assign bus.w_ready      = flags_q.w_ready;
    assign bus.x_ready      = flags_q.x_ready;
    assign bus.store_weight = store_weight;
    assign bus.lane_valid   = lane_valid;
    assign bus.res_valid    = res_valid;

    a_sw_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(store_weight));
    a_sw_in_load: assert property (@(posedge clk) disable iff (!rst_n)
        (store_weight != '0) |-> (state_q == LOAD));
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(flags_q.w_ready && flags_q.x_ready));

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench for pe_array_sequencer: directed jobs plus randomized jobs
// compared each cycle against a counter/queue reference model.
module tb_pe_array_sequencer;
    import tpu_ctrl_pkg::*;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAT   = seq_latency(ROWS, COLS);
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pe_array_sequencer_if #(.ROWS(ROWS), .CNT_W(CNT_W)) bus ();

    pe_array_sequencer #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: job progress expressed as counts plus a history of injected lanes.
    bit m_active;
    int m_rows, m_vecs, m_nv, m_drain, m_stall;
    bit hist[$];

    int cyc;
    int res_log[$];
    int xhs_log[$];
    int sw_cyc[$];
    int sw_val[$];
    int done_cyc;
    int xr_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_clear();
        m_active = 1'b0;
        m_rows = 0; m_vecs = 0; m_nv = 0; m_drain = 0; m_stall = 0;
        hist.delete();
    endtask

    task automatic tick(input logic st, input logic [CNT_W-1:0] nv, input logic wv, input logic xv);
        bit e_load, e_stream, e_drain, e_done, e_lane, e_res;
        logic [ROWS-1:0] e_sw;
        int e_stall;
        bus.start = st; bus.num_vectors = nv; bus.w_valid = wv; bus.x_valid = xv;
        @(negedge clk);
        e_load   = m_active && (m_rows < ROWS);
        e_stream = m_active && !e_load && (m_vecs < m_nv);
        e_drain  = m_active && !e_load && !e_stream && (m_nv != 0) && (m_drain < LAT);
        e_done   = m_active && !e_load && !e_stream && !e_drain;
        e_sw = '0;
        if (e_load && wv) e_sw[m_rows] = 1'b1;
        e_lane = e_stream && xv;
        e_res  = (hist.size() >= LAT) ? hist[LAT-1] : 1'b0;
`ifdef SEQ_PERF_COUNTERS_EN
        e_stall = m_stall;
`else
        e_stall = 0;
`endif
        chk("ctrl_flags", {bus.busy, bus.done, bus.w_ready, bus.x_ready},
            {m_active, e_done, e_load, e_stream});
        chk("store_weight", bus.store_weight, e_sw);
        chk("lane_valid", bus.lane_valid, e_lane);
        chk("res_valid", bus.res_valid, e_res);
        chk("stall_cycles", bus.stall_cycles, e_stall);

        if (bus.res_valid === 1'b1) res_log.push_back(cyc);
        if (bus.x_ready === 1'b1 && xv) xhs_log.push_back(cyc);
        if (bus.store_weight !== '0) begin
            sw_cyc.push_back(cyc);
            sw_val.push_back(int'(bus.store_weight));
        end
        if (bus.done === 1'b1) done_cyc = cyc;
        if (bus.x_ready === 1'b1) xr_cnt++;

        if (!m_active) begin
            if (st) begin
                m_active = 1'b1; m_nv = int'(nv);
                m_rows = 0; m_vecs = 0; m_drain = 0; m_stall = 0;
            end
        end else if (e_load) begin
            if (wv) m_rows++;
        end else if (e_stream) begin
            if (xv) m_vecs++;
            else if (m_stall < CMAX) m_stall++;
        end else if (e_drain) begin
            m_drain++;
        end else begin
            m_active = 1'b0;
        end
        hist.push_front(e_lane);
        if (hist.size() > LAT) void'(hist.pop_back());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // wmode/xmode: 0 = always valid, 1 = directed pattern, 2 = random.
    // poke: 1 = start pulse on 2nd stream cycle, 2 = random start pulses while busy.
    task automatic run_job(input int nv, input int wmode, input int xmode, input int poke, input int abort_hs);
        int xi;
        bit wv, xv, st, in_load, in_stream;
        logic [CNT_W-1:0] nvd;
        bit [0:5] xpat = 6'b100111;
        res_log.delete(); xhs_log.delete(); sw_cyc.delete(); sw_val.delete();
        done_cyc = -1; xr_cnt = 0; cyc = 0; xi = 0;
        tick(1'b1, CNT_W'(nv), 1'($urandom), 1'($urandom));
        for (int n = 0; n < 2000 && m_active; n++) begin
            in_load   = (m_rows < ROWS);
            in_stream = !in_load && (m_vecs < m_nv);
            if (abort_hs >= 0 && in_stream && m_vecs == abort_hs) return;
            case (wmode)
                0:       wv = 1'b1;
                1:       wv = (cyc % 2 == 1);
                default: wv = ($urandom_range(0, 3) != 0);
            endcase
            case (xmode)
                0:       xv = 1'b1;
                1:       xv = (xi < 6) ? xpat[xi] : 1'b1;
                default: xv = ($urandom_range(0, 3) != 0);
            endcase
            if (in_stream) xi++;
            st = 1'b0; nvd = CNT_W'(nv);
            if (poke == 1 && in_stream && xi == 2) begin st = 1'b1; nvd = CNT_W'(1); end
            if (poke == 2 && $urandom_range(0, 7) == 0) begin st = 1'b1; nvd = CNT_W'($urandom_range(0, 20)); end
            tick(st, nvd, wv, xv);
        end
        chk("job_end_idle", bus.busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", {bus.busy, bus.done, bus.w_ready, bus.x_ready, bus.lane_valid,
                              bus.res_valid, bus.store_weight, bus.stall_cycles}, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.num_vectors = '0; bus.w_valid = 1'b0; bus.x_valid = 1'b0;
        model_clear();
        do_reset();

        // Basic job, everything valid
        run_job(3, 0, 0, 0, -1);
        for (int i = 0; i < 4; i++) begin
            chk("basic_sw_cycle", qget(sw_cyc, i), i + 1);
            chk("basic_sw_value", qget(sw_val, i), 1 << i);
        end
        for (int i = 0; i < 3; i++) begin
            chk("basic_x_hs", qget(xhs_log, i), 5 + i);
            chk("basic_res", qget(res_log, i), 12 + i);
        end
        chk("basic_res_count", res_log.size(), 3);
        chk("basic_done", done_cyc, 15);

        // Weight stalls
        run_job(2, 1, 0, 0, -1);
        chk("wstall_count", sw_cyc.size(), 4);
        for (int i = 0; i < 4; i++) chk("wstall_cycle", qget(sw_cyc, i), 1 + 2 * i);
        chk("wstall_first_x", qget(xhs_log, 0), 8);

        // Input bubbles
        run_job(4, 0, 1, 0, -1);
        chk("bubble_res_count", res_log.size(), 4);
        chk("bubble_res0", qget(res_log, 0), 12);
        chk("bubble_res1", qget(res_log, 1), 15);
        chk("bubble_res2", qget(res_log, 2), 16);
        chk("bubble_res3", qget(res_log, 3), 17);
        chk("bubble_done", done_cyc, 18);
`ifdef SEQ_PERF_COUNTERS_EN
        chk("bubble_stall", bus.stall_cycles, 2);
`else
        chk("bubble_stall", bus.stall_cycles, 0);
`endif

        // Zero vectors
        run_job(0, 0, 0, 0, -1);
        chk("zero_sw_count", sw_cyc.size(), 4);
        chk("zero_done", done_cyc, 5);
        chk("zero_x_ready", xr_cnt, 0);
        chk("zero_res", res_log.size(), 0);

        // Start pulse while busy must be ignored
        run_job(5, 0, 0, 1, -1);
        chk("poke_x_hs", xhs_log.size(), 5);
        chk("poke_done", done_cyc, 17);

        // Reset mid-stream after two handshakes, then a clean single-vector job
        run_job(6, 0, 0, 0, 2);
        chk("abort_hs_seen", xhs_log.size(), 2);
        do_reset();
        run_job(1, 0, 0, 0, -1);
        chk("after_reset_res_count", res_log.size(), 1);
        chk("after_reset_res", qget(res_log, 0), 12);
        chk("after_reset_done", done_cyc, 13);

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            int gap;
            run_job($urandom_range(0, 9), 2, 2, 2, -1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick(1'b0, '0, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Controls a ROWS x COLS weight-stationary array of basic PEs.
- Runs one job as two phases:
  - Weight load: drives the per-row store_weight strobes one row at a time from a weight stream.
  - Compute: admits input vectors through a valid/ready handshake, then produces result-valid timing that matches the array's skew and drain latency.
- Sits between the host/DMA front end and the array datapath. It contains no arithmetic of its own.

Parameters:
- ROWS, 4, number of PE rows (one stored weight per row strobe).
- COLS, 4, number of PE columns.
- CNT_W, 16, width of the vector counter.
- LAT, ROWS+COLS-1, cycles from input handshake to the matching result row being valid (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start request; sampled only in IDLE.
- num_vectors  in  CNT_W  number of input vectors in the job; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the job completes.
- w_valid  in  1  weight row word available on the array's top bus.
- w_ready  out  1  sequencer accepts a weight row.
- store_weight  out  ROWS  one-hot row strobe into the PE store_weight inputs.
- x_valid  in  1  input vector available.
- x_ready  out  1  sequencer accepts an input vector.
- lane_valid  out  1  datapath injects the vector (high) or zeros (low) into the skew buffers.
- res_valid  out  1  result row at the array bottom is valid this cycle.
- stall_cycles  out  CNT_W  performance counter (see Optional Feature).

Behaviour:
- Reset state: IDLE. Outputs during reset: busy=0, done=0, w_ready=0, x_ready=0, store_weight=0, lane_valid=0, res_valid=0, stall_cycles=0.
- Reset mid-job aborts immediately, clears all counters and the valid pipe, and returns to IDLE.
- States: IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On start=1, latch num_vectors, clear row_idx and vec_cnt, go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - w_ready=1.
  - store_weight[row_idx] = w_valid. This is combinational, so the strobe coincides with the handshake.
  - row_idx increments on each handshake, row 0 first.
  - On the handshake with row_idx==ROWS-1: go to STREAM, or go directly to DONE if num_vectors==0 (weights-only job).
  - w_valid low inserts a wait cycle with store_weight all zero.
- STREAM:
  - x_ready=1 and lane_valid = x_valid.
  - vec_cnt increments on each handshake.
  - On the handshake with vec_cnt==num_vectors-1, go to DRAIN.
  - A cycle with no handshake injects a zero bubble (lane_valid=0). The PEs have no enable, so the array always advances.
- DRAIN:
  - x_ready=0, lane_valid=0.
  - A drain counter runs for LAT cycles, then the state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- res_valid:
  - Equals lane_valid delayed by exactly LAT cycles through a shift register.
  - A bubble therefore yields res_valid=0 at that slot.
  - The final res_valid occurs on the last DRAIN cycle, before done.
- Invariants (asserted):
  - store_weight is nonzero only in LOAD, and is never multi-hot.
  - w_ready and x_ready are never high together.
- num_vectors is interpreted as unsigned; the maximum is 2^CNT_W-1. Counters never wrap within a job.

Optional Feature:
- Macro: SEQ_PERF_COUNTERS_EN.
- When defined:
  - stall_cycles increments on every STREAM cycle with x_valid=0.
  - It saturates at all-ones, clears on start, and holds after done.
- When undefined: stall_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Package tpu_ctrl_pkg holds:
  - the state enum seq_state_e (IDLE, LOAD, STREAM, DRAIN, DONE);
  - a localparam helper function for LAT.
- Sub-module pe_valid_pipe: a parameterized DEPTH single-bit shift register with async reset, used to generate res_valid.

Test Plan:
- Basic job: ROWS=COLS=4, start with num_vectors=3, w_valid and x_valid held high.
  - store_weight = 0001, 0010, 0100, 1000 on cycles 1-4.
  - x handshakes on cycles 5-7.
  - res_valid on cycles 12-14.
  - done on cycle 15.
- Weight stalls: w_valid toggles 1,0,1,0,... in LOAD.
  - store_weight is asserted only on high cycles.
  - Exactly 4 strobes are issued, then the state enters STREAM.
- Input bubbles: num_vectors=4 with x_valid pattern 1,0,0,1,1,1.
  - res_valid pattern is 1,0,0,1,1,1, delayed 7 cycles.
  - stall_cycles=2 when SEQ_PERF_COUNTERS_EN is defined, 0 otherwise.
- Zero vectors: num_vectors=0.
  - 4 weight strobes, then done one cycle later.
  - x_ready and res_valid never assert.
- Reset mid-job: rst_n low during STREAM after 2 handshakes.
  - All outputs are 0 immediately.
  - A following start with num_vectors=1 completes a normal job with no stale res_valid.
- Start ignored while busy: start pulsed in STREAM has no effect on vec_cnt or the latched num_vectors.
